// File: rtl/posit_pkg.sv
// Shared types for the posit div/sqrt unit and its requester-side issuer.
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT16 = 2'd0,
        POSIT8  = 2'd1,
        POSIT32 = 2'd2
    } posit_format_e;

    typedef enum logic {
        DIV  = 1'b0,
        SQRT = 1'b1
    } operation_e;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RDN = 2'd2,
        RUP = 2'd3
    } roundmode_e;

    // Exception flags: invalid, divide-by-zero, overflow, underflow, inexact.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned posit_width(input posit_format_e fmt);
        case (fmt)
            POSIT8:  return 8;
            POSIT32: return 32;
            default: return 16;
        endcase
    endfunction

    // Response record for the default format; other formats build the same
    // layout locally with their own result width.
    localparam int unsigned DEFAULT_WIDTH = posit_width(posit_format_e'(0));

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] result;
        status_t                  status;
        logic                     tag;
    } posit_divsqrt_rsp_t;

endpackage

// File: rtl/posit_divsqrt_rsp_fifo.sv
// Circular response queue; head entry is read straight from storage flops.
module posit_divsqrt_rsp_fifo
    import posit_pkg::*;
#(
    parameter type         entry_t = posit_divsqrt_rsp_t,
    parameter int unsigned DEPTH   = 2
)(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign push_ok = push_i & ~flush_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~flush_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    // One storage slot per entry, written when the write pointer selects it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_q[gi] <= '0;
            end else if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/posit_divsqrt_issuer.sv
// Core-side front end for the combinational posit div/sqrt unit: holds one
// request, hands it to the unit, and queues results for the core.
module posit_divsqrt_issuer
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat = posit_format_e'(0),
    parameter int unsigned   DEPTH   = 2,
    localparam int unsigned  WIDTH   = posit_width(pFormat)
)(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [1:0][WIDTH-1:0]  req_operands_i,
    input  operation_e             req_op_i,
    input  roundmode_e             req_rnd_i,
    input  logic                   req_tag_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    output logic [1:0][WIDTH-1:0]  du_operands_o,
    output operation_e             du_op_o,
    output roundmode_e             du_rnd_o,
    output logic                   du_tag_o,
    output logic                   du_valid_o,
    input  logic                   du_ready_i,
    input  logic [WIDTH-1:0]       du_result_i,
    input  status_t                du_status_i,
    input  logic                   du_tag_i,
    input  logic                   du_valid_i,
    output logic                   du_ready_o,
    output logic                   du_flush_o,
    output logic [WIDTH-1:0]       rsp_result_o,
    output status_t                rsp_status_o,
    output logic                   rsp_tag_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o
);

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        logic             tag;
    } rsp_t;

    state_e               state_q, state_d;
    logic [1:0][WIDTH-1:0] operands_q;
    operation_e           op_q;
    roundmode_e           rnd_q;
    logic                 tag_q;

    logic space, issue_fire, accept, push, pop;
    logic fifo_full, fifo_empty;
    rsp_t push_data, head;

    // Handshake terms and next state. A slot exists if the queue has room or
    // its head is leaving this cycle; flush suppresses every transfer.
    always_comb begin
        space       = ~fifo_full | (rsp_valid_o & rsp_ready_i);
        du_valid_o  = (state_q == ISSUE) & space & ~flush_i;
        issue_fire  = du_valid_o & du_ready_i;
        du_ready_o  = space & ~flush_i;
        req_ready_o = ~flush_i & ((state_q == IDLE) | issue_fire);
        accept      = req_valid_i & req_ready_o;
        // The unit is combinational, so a result is only genuine alongside our issue.
        push        = du_valid_i & du_ready_o & du_valid_o;
        pop         = rsp_valid_o & rsp_ready_i;
        state_d     = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = ISSUE;
                ISSUE:   if (issue_fire && !accept) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Request register; reloads whenever a request is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            operands_q <= '0;
            op_q       <= DIV;
            rnd_q      <= RNE;
            tag_q      <= 1'b0;
        end else if (accept) begin
            operands_q <= req_operands_i;
            op_q       <= req_op_i;
            rnd_q      <= req_rnd_i;
            tag_q      <= req_tag_i;
        end
    end

    // Pack the unit's result for the response queue.
    always_comb begin
        push_data        = '0;
        push_data.result = du_result_i;
        push_data.status = du_status_i;
        push_data.tag    = du_tag_i;
    end

    posit_divsqrt_rsp_fifo #(
        .entry_t (rsp_t),
        .DEPTH   (DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign du_operands_o = operands_q;
    assign du_op_o       = op_q;
    assign du_rnd_o      = rnd_q;
    assign du_tag_o      = tag_q;
    assign du_flush_o    = flush_i;
    assign rsp_result_o  = head.result;
    assign rsp_status_o  = head.status;
    assign rsp_tag_o     = head.tag;
    assign rsp_valid_o   = ~fifo_empty;
    assign busy_o        = (state_q == ISSUE) | ~fifo_empty;

endmodule

// File: tb/tb_posit_divsqrt_issuer.sv
module tb_posit_divsqrt_issuer;
    import posit_pkg::*;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_ni, flush_i;
    logic [1:0][W-1:0] req_operands_i;
    operation_e       req_op_i;
    roundmode_e       req_rnd_i;
    logic             req_tag_i, req_valid_i, req_ready_o;
    logic [1:0][W-1:0] du_operands_o;
    operation_e       du_op_o;
    roundmode_e       du_rnd_o;
    logic             du_tag_o, du_valid_o, du_ready_i;
    logic [W-1:0]     du_result_i;
    status_t          du_status_i;
    logic             du_tag_i, du_valid_i, du_ready_o, du_flush_o;
    logic [W-1:0]     rsp_result_o;
    status_t          rsp_status_o;
    logic             rsp_tag_o, rsp_valid_o, rsp_ready_i, busy_o;

    logic stall, spur;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic [W-1:0] result;
        status_t      status;
        logic         tag;
    } exp_t;

    typedef struct {
        operation_e op;
        logic [W-1:0] a, b;
        logic       tag;
        roundmode_e rnd;
        logic [W-1:0] exp_res;
        logic [4:0] exp_st;
    } vec_t;

    vec_t vecs [6];
    exp_t sb_q [$];
    exp_t sb_e, unit_out;

    always #5 clk = ~clk;

    posit_divsqrt_issuer #(.pFormat(POSIT16), .DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_rnd_i(req_rnd_i),
        .req_tag_i(req_tag_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .du_operands_o(du_operands_o), .du_op_o(du_op_o), .du_rnd_o(du_rnd_o),
        .du_tag_o(du_tag_o), .du_valid_o(du_valid_o), .du_ready_i(du_ready_i),
        .du_result_i(du_result_i), .du_status_i(du_status_i), .du_tag_i(du_tag_i),
        .du_valid_i(du_valid_i), .du_ready_o(du_ready_o), .du_flush_o(du_flush_o),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .busy_o(busy_o)
    );

    // Stand-in for the div/sqrt unit: a deterministic map of the operands.
    function automatic exp_t unit_f(input operation_e op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic tag);
        exp_t e;
        e = '0;
        e.tag = tag;
        if (op == DIV) begin
            if (b == '0) begin
                e.result = 16'h8000;
                e.status.DZ = 1'b1;
            end else if (a == b) begin
                e.result = 16'h4000;
            end else begin
                e.result = a - b;
                e.status.NX = 1'b1;
            end
        end else begin
            if (a == 16'h4000) begin
                e.result = 16'h4000;
            end else begin
                e.result = a >> 1;
                e.status.NX = 1'b1;
            end
        end
        return e;
    endfunction

    // Combinational unit: input ready follows output ready, result same cycle.
    always_comb begin
        unit_out    = unit_f(du_op_o, du_operands_o[0], du_operands_o[1], du_tag_o);
        du_result_i = unit_out.result;
        du_status_i = unit_out.status;
        du_tag_i    = unit_out.tag;
        du_valid_i  = spur | (du_valid_o & ~stall);
        du_ready_i  = du_ready_o & ~stall;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected results are queued at accept and must leave in order.
    always @(negedge clk) begin
        if (!rst_ni || flush_i) begin
            sb_q.delete();
        end else begin
            if (rsp_valid_o && rsp_ready_i) begin
                check("sb_rsp_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("sb_result", 32'(rsp_result_o), 32'(sb_e.result));
                    check("sb_status", 32'(rsp_status_o), 32'(sb_e.status));
                    check("sb_tag", 32'(rsp_tag_o), 32'(sb_e.tag));
                    $display("rsp tag=%0d result=%h status=%b", rsp_tag_o, rsp_result_o, rsp_status_o);
                end
            end
            if (req_valid_i && req_ready_o)
                sb_q.push_back(unit_f(req_op_i, req_operands_i[0], req_operands_i[1], req_tag_i));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input operation_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic tag, input roundmode_e rnd);
        req_op_i = op;
        req_operands_i[0] = a;
        req_operands_i[1] = b;
        req_tag_i = tag;
        req_rnd_i = rnd;
    endtask

    // One isolated request with exact 2-cycle accept-to-response timing.
    task automatic apply_vec(input int i);
        set_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].rnd);
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b0;
        #1 check("vec_req_ready", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        #1;
        check("vec_du_valid", 32'(du_valid_o), 32'd1);
        check("vec_du_opa", 32'(du_operands_o[0]), 32'(vecs[i].a));
        check("vec_du_rnd", 32'(du_rnd_o), 32'(vecs[i].rnd));
        check("vec_rsp_early", 32'(rsp_valid_o), 32'd0);
        step();
        #1;
        check("vec_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("vec_result", 32'(rsp_result_o), 32'(vecs[i].exp_res));
        check("vec_status", 32'(rsp_status_o), 32'(vecs[i].exp_st));
        check("vec_tag", 32'(rsp_tag_o), 32'(vecs[i].tag));
        $display("vec %0d op=%0d a=%h b=%h -> result=%h status=%b", i, vecs[i].op,
                 vecs[i].a, vecs[i].b, rsp_result_o, rsp_status_o);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        #1;
        check("vec_rsp_gone", 32'(rsp_valid_o), 32'd0);
        check("vec_idle", 32'(busy_o), 32'd0);
        step();
    endtask

    task automatic wait_idle(input string name);
        int t;
        rsp_ready_i = 1'b1;
        t = 0;
        while (busy_o && t < 50) begin
            step();
            t++;
        end
        check(name, 32'(busy_o), 32'd0);
        step();
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        vecs[0] = '{DIV,  16'h4000, 16'h4000, 1'b1, RNE, 16'h4000, 5'b00000};
        vecs[1] = '{DIV,  16'h3000, 16'h0000, 1'b0, RTZ, 16'h8000, 5'b01000};
        vecs[2] = '{SQRT, 16'h4000, 16'h0000, 1'b0, RDN, 16'h4000, 5'b00000};
        vecs[3] = '{SQRT, 16'h1234, 16'h0000, 1'b1, RUP, 16'h091A, 5'b00001};
        vecs[4] = '{DIV,  16'h5000, 16'h1000, 1'b1, RNE, 16'h4000, 5'b00001};
        vecs[5] = '{DIV,  16'h0000, 16'h0000, 1'b0, RNE, 16'h8000, 5'b01000};

        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        stall = 1'b0; spur = 1'b0;
        set_req(DIV, '0, '0, 1'b0, RNE);
        #3;
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_du_valid", 32'(du_valid_o), 32'd0);
        check("rst_du_ready", 32'(du_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rsp_result", 32'(rsp_result_o), 32'd0);
        check("rst_du_operands", 32'(du_operands_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Table-driven single operations, including divide-by-zero status.
        for (int i = 0; i < 6; i++) apply_vec(i);

        // Eight back-to-back SQRTs with alternating tags.
        rsp_ready_i = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                set_req(SQRT, W'($urandom), '0, 1'(cyc % 2), RNE);
                req_valid_i = 1'b1;
            end else begin
                req_valid_i = 1'b0;
            end
            #1;
            if (cyc < 8) check("b2b_req_ready", 32'(req_ready_o), 32'd1);
            check("b2b_rsp_valid", 32'(rsp_valid_o), 32'(cyc >= 2));
            if (cyc >= 2) check("b2b_tag", 32'(rsp_tag_o), 32'((cyc - 2) % 2));
            step();
        end
        #1 check("b2b_drained", 32'(rsp_valid_o), 32'd0);
        step();

        // Backpressure: two queued, third held, fourth waits.
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(SQRT, W'($urandom), '0, 1'(k % 2), RNE);
            req_valid_i = 1'b1;
            step();
        end
        set_req(DIV, 16'h6000, 16'h2000, 1'b1, RNE);
        for (int h = 0; h < 3; h++) begin
            #1;
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
            check("bp_du_valid", 32'(du_valid_o), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_head_tag", 32'(rsp_tag_o), 32'd0);
            step();
        end
        rsp_ready_i = 1'b1;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            #1 got = int'(req_ready_o);
            step();
        end
        req_valid_i = 1'b0;
        check("bp_accept_4th", 32'(got), 32'd1);
        wait_idle("bp_drain");

        // Flush with the queue full and a request held.
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(DIV, W'($urandom), W'($urandom), 1'(k % 2), RNE);
            req_valid_i = 1'b1;
            step();
        end
        #1;
        check("fl_pre_busy", 32'(busy_o), 32'd1);
        check("fl_pre_full_block", 32'(req_ready_o), 32'd0);
        flush_i = 1'b1;
        #1;
        check("fl_req_ready", 32'(req_ready_o), 32'd0);
        check("fl_du_valid", 32'(du_valid_o), 32'd0);
        check("fl_du_ready", 32'(du_ready_o), 32'd0);
        check("fl_du_flush", 32'(du_flush_o), 32'd1);
        step();
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check("fl_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("fl_busy", 32'(busy_o), 32'd0);
        check("fl_req_ready_after", 32'(req_ready_o), 32'd1);
        rsp_ready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            check("fl_no_stale", 32'(rsp_valid_o), 32'd0);
        end

        // A unit valid without our issue must not create a response.
        rsp_ready_i = 1'b0;
        spur = 1'b1;
        step();
        spur = 1'b0;
        #1;
        check("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("spur_busy", 32'(busy_o), 32'd0);
        step();

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            req_valid_i = ($urandom_range(0, 99) < 60);
            set_req(operation_e'($urandom_range(0, 1)), W'($urandom),
                    ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
                    1'($urandom_range(0, 1)), roundmode_e'($urandom_range(0, 3)));
            rsp_ready_i = ($urandom_range(0, 99) < 70);
            stall = ($urandom_range(0, 99) < 20);
            step();
        end
        req_valid_i = 1'b0;
        stall = 1'b0;
        wait_idle("rand_drain");

        // Asynchronous reset mid-stream.
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(SQRT, W'($urandom), '0, 1'(k % 2), RNE);
            req_valid_i = 1'b1;
            step();
        end
        #2 rst_ni = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check("arst_du_valid", 32'(du_valid_o), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_du_operands", 32'(du_operands_o), 32'd0);
        #8 rst_ni = 1'b1;
        step();
        apply_vec(0);
        apply_vec(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
